risc_core: RTL and testbench
============================

// Module: risc_core
// PURPOSE
//  Single-cycle 16-bit-instruction RISC core: 8 general registers, internal data RAM.
//  Fetches from an external instruction ROM addressed by pc (combinational read).
//  Executes one instruction per clock.
//  Top-level processing element; the instruction ROM is outside the block.
// PARAMETERS
//  A_SIZE  10  width of pc and of data-RAM address; RAM depth = 2**A_SIZE words
//  D_SIZE  32  width of registers and data-RAM words
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       reset, synchronous, active-low
//  pc           out  A_SIZE  program counter = instruction ROM address (registered)
//  instruction  in   16      instruction word at pc, valid combinationally in same cycle
// BEHAVIOUR
//  Clock and reset: one clock (clk); rst is synchronous and active-low.
//  Reset: posedge with rst=0 -> pc=0, R0..R7=0, halted=0. Data RAM is not cleared.
//   Reset mid-program aborts the current instruction, with no register or RAM write.
//  Normal cycle (rst=1, not halted), all state updated at posedge:
//   - decode and execute the instruction present on `instruction`;
//   - pc <= pc+1, wrapping 2**A_SIZE-1 -> 0, unless a jump or halt applies.
//  Encoding, ALU group ([15:13]=000):
//   - fields: op7=[15:9], d=[8:6], s1=[5:3], s2=[2:0];
//   - 0000000 NOP;
//   - 0000001 ADD: R[d] <= R[s1] + R[s2];
//   - 0000011 SUB: R[d] <= R[s1] - R[s2];
//   - 0000101 AND; 0000110 OR; 0000111 XOR (all R[d] <= R[s1] op R[s2]);
//   - arithmetic is modulo 2**D_SIZE; carry/borrow dropped; no flags;
//   - d may equal s1/s2; sources are read before the write.
//  Encoding, memory/jump group: op5=[15:11], r=[10:8], k=[7:0], s=[2:0]:
//   - 00100 LOAD:  R[r] <= RAM[R[s][A_SIZE-1:0]];
//   - 00101 LOADC: R[r] <= {zeros, k}, zero-extended to D_SIZE;
//   - 00110 STORE: RAM[R[r][A_SIZE-1:0]] <= R[s];
//   - 01000 JMP:   pc <= R[s][A_SIZE-1:0];
//   - 01100 HALT:  pc holds, halted=1; only reset clears it.
//  Any other encoding executes as NOP (pc+1).
//  RAM: one synchronous write port, one asynchronous read port.
//   - LOAD from an address sees the value of a STORE to it only in a later cycle.
//  Register file: 8 x D_SIZE, two async read ports, one write port at posedge.
//  X on instruction (unprogrammed ROM word) is not trapped; the bench avoids it.
// TESTING
//  1 Reset: rst=0 for 2 edges -> pc=0, R0..R7=0.
//    Release -> pc reads 1, 2, 3 on successive edges.
//  2 LOADC: 16'h2807 then 16'h2906 -> R0=7, R1=6.
//    Then 16'h2C01 -> R4=1, upper D_SIZE-8 bits = 0.
//  3 ALU program, in order:
//    - LOADC R0..R7 = 7,6,7,7,1,7,7,7;
//    - ADD 16'h020B -> R0=13;
//    - ADD 16'h0287 -> R2=20;
//    - SUB 16'h0601 -> R0=7;
//    - pc=11 after the SUB.
//  4 Memory: R0=7, R2=20.
//    - STORE 16'h3002 -> RAM[7]=20;
//    - then LOAD 16'h2000 -> R0=20.
//  5 Wrap, JMP, HALT:
//    - SUB 1-7 -> 2**D_SIZE-6;
//    - JMP to R4=1 -> pc=1;
//    - HALT 16'h6000 -> pc frozen until rst=0.
//  6 Reset mid-run: rst=0 during the ADD cycle -> no R[d] write, pc=0 next edge.

Source files
------------

// File: rtl/risc_core.sv
// risc_core
//   Single-cycle RISC processing element. It uses 16-bit instructions, eight
//   D_SIZE-bit general registers and an internal data RAM of 2**A_SIZE words.
//   Instructions come from an external ROM, which this block addresses with pc
//   and reads combinationally. The core retires one instruction per clock and
//   updates all of its state on the rising edge of clk.
//
// Ports
//   clk          in   1        rising-edge clock
//   rst          in   1        synchronous, active-low reset
//   pc           out  A_SIZE   program counter / instruction ROM address (registered)
//   instruction  in   16       instruction word at pc, valid in the same cycle
//
// Instruction groups
//   ALU  : op7=[15:9] d=[8:6] s1=[5:3] s2=[2:0]
//          NOP / ADD / SUB / AND / OR / XOR
//   MEM  : op5=[15:11] r=[10:8] k=[7:0] s=[2:0]
//          LOAD / LOADC / STORE / JMP / HALT
//   Any other encoding retires as a NOP.
module risc_core #(
  parameter int A_SIZE = 10,
  parameter int D_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic [A_SIZE-1:0] pc,
  input  logic [15:0]       instruction
);

  localparam int DEPTH = 2 ** A_SIZE;

  localparam logic [6:0] OP7_ADD = 7'b0000001;
  localparam logic [6:0] OP7_SUB = 7'b0000011;
  localparam logic [6:0] OP7_AND = 7'b0000101;
  localparam logic [6:0] OP7_OR  = 7'b0000110;
  localparam logic [6:0] OP7_XOR = 7'b0000111;

  localparam logic [4:0] OP5_LOAD  = 5'b00100;
  localparam logic [4:0] OP5_LOADC = 5'b00101;
  localparam logic [4:0] OP5_STORE = 5'b00110;
  localparam logic [4:0] OP5_JMP   = 5'b01000;
  localparam logic [4:0] OP5_HALT  = 5'b01100;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [A_SIZE-1:0] r_pc;
  logic [A_SIZE-1:0] w_pc_nxt;

  logic [D_SIZE-1:0] r_rf  [8];
  logic [D_SIZE-1:0] r_ram [DEPTH];

  // Decoded instruction fields.
  logic [6:0]        w_op7;
  logic [4:0]        w_op5;
  logic [2:0]        w_d;
  logic [2:0]        w_s1;
  logic [2:0]        w_s2;
  logic [2:0]        w_r;
  logic [7:0]        w_k;

  // Register file read ports. The s field of the memory group occupies the
  // same bits as s2, so one port serves both groups.
  logic [D_SIZE-1:0] w_rs1;
  logic [D_SIZE-1:0] w_rs2;

  logic              w_rf_we;
  logic [2:0]        w_rf_waddr;
  logic [D_SIZE-1:0] w_rf_wdata;
  logic              w_ram_we;
  logic [A_SIZE-1:0] w_ram_waddr;
  logic [D_SIZE-1:0] w_ram_wdata;

  function automatic logic [D_SIZE-1:0] f_alu(input logic [6:0]        op,
                                               input logic [D_SIZE-1:0] a,
                                               input logic [D_SIZE-1:0] b);
    logic [D_SIZE-1:0] res;
    case (op)
      OP7_ADD: res = a + b;
      OP7_SUB: res = a - b;
      OP7_AND: res = a & b;
      OP7_OR:  res = a | b;
      OP7_XOR: res = a ^ b;
      default: res = '0;
    endcase
    return res;
  endfunction

  assign w_op7 = instruction[15:9];
  assign w_op5 = instruction[15:11];
  assign w_d   = instruction[8:6];
  assign w_s1  = instruction[5:3];
  assign w_s2  = instruction[2:0];
  assign w_r   = instruction[10:8];
  assign w_k   = instruction[7:0];

  assign w_rs1 = r_rf[w_s1];
  assign w_rs2 = r_rf[w_s2];

  assign pc    = r_pc;

  // Decode and execute.
  always_comb begin
    w_pc_nxt    = r_pc + 1'b1;
    w_state_nxt = r_state;
    w_rf_we     = 1'b0;
    w_rf_waddr  = w_d;
    w_rf_wdata  = '0;
    w_ram_we    = 1'b0;
    w_ram_waddr = '0;
    w_ram_wdata = w_rs2;

    if (r_state == ST_HALT) begin
      w_pc_nxt = r_pc;
    end else if (rst) begin
      // The ALU opcodes all have [15:11]=00000, so the two decodes never
      // overlap.
      case (w_op7)
        OP7_ADD, OP7_SUB, OP7_AND, OP7_OR, OP7_XOR: begin
          w_rf_we    = 1'b1;
          w_rf_waddr = w_d;
          w_rf_wdata = f_alu(w_op7, w_rs1, w_rs2);
        end
        default: ;
      endcase

      case (w_op5)
        OP5_LOAD: begin
          w_rf_we    = 1'b1;
          w_rf_waddr = w_r;
          w_rf_wdata = r_ram[w_rs2[A_SIZE-1:0]];
        end
        OP5_LOADC: begin
          w_rf_we    = 1'b1;
          w_rf_waddr = w_r;
          w_rf_wdata = {{(D_SIZE-8){1'b0}}, w_k};
        end
        OP5_STORE: begin
          w_ram_we    = 1'b1;
          w_ram_waddr = r_rf[w_r][A_SIZE-1:0];
        end
        OP5_JMP: begin
          w_pc_nxt = w_rs2[A_SIZE-1:0];
        end
        OP5_HALT: begin
          w_pc_nxt    = r_pc;
          w_state_nxt = ST_HALT;
        end
        default: ;
      endcase
    end
  end

  // State register: once halted, only reset returns the core to RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC and register file. Reset aborts the instruction in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc <= '0;
      for (int i = 0; i < 8; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      r_pc <= w_pc_nxt;
      if (w_rf_we) begin
        r_rf[w_rf_waddr] <= w_rf_wdata;
      end
    end
  end

  // Data RAM keeps its contents through reset. Because the read port is
  // asynchronous, a LOAD in the same cycle as a STORE sees the old word.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_ram_waddr] <= w_ram_wdata;
    end
  end

endmodule

// File: tb/tb_risc_core.sv
// tb_risc_core
//   Bench for risc_core. The bench acts as the instruction ROM and drives the
//   instruction word on each negedge. A small ISA interpreter keeps the
//   architectural state that the core must have: pc, R0..R7, the RAM and the
//   halt flag. A compare process checks the core against that state after
//   every rising edge. Directed programs use hand-computed values. A long
//   randomized phase then generates instructions from the interpreter's
//   current state.
module tb_risc_core;

  localparam int A_SIZE = 10;
  localparam int D_SIZE = 32;
  localparam int DEPTH  = 1 << A_SIZE;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [15:0]       instruction = 16'h0000;
  logic [A_SIZE-1:0] pc;

  risc_core #(.A_SIZE(A_SIZE), .D_SIZE(D_SIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .instruction(instruction)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Architectural reference state.
  bit [D_SIZE-1:0] m_r   [8];
  bit [A_SIZE-1:0] m_pc;
  bit              m_halt;
  bit [D_SIZE-1:0] m_ram    [DEPTH];
  bit              m_ram_ok [DEPTH];
  int              last_store = -1;

  logic [6:0] alu_ops [5] = '{7'd1, 7'd3, 7'd5, 7'd6, 7'd7};
  logic [6:0] nop_ops [6] = '{7'd0, 7'd2, 7'd4, 7'd8, 7'd12, 7'd15};

  task automatic check(input string name, input logic [D_SIZE-1:0] act,
                       input logic [D_SIZE-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One instruction of the ISA, applied to the reference state.
  function automatic void model_step(input logic r, input logic [15:0] ins);
    bit [A_SIZE-1:0] nxt;
    bit [A_SIZE-1:0] addr;
    bit [D_SIZE-1:0] a;
    bit [D_SIZE-1:0] b;
    last_store = -1;
    if (r !== 1'b1) begin
      m_pc   = '0;
      m_halt = 1'b0;
      for (int i = 0; i < 8; i++) m_r[i] = '0;
      return;
    end
    if (m_halt) return;
    nxt = m_pc + 1'b1;
    a   = m_r[ins[5:3]];
    b   = m_r[ins[2:0]];
    if (ins[15:13] == 3'b000) begin
      case (ins[15:9])
        7'd1: m_r[ins[8:6]] = a + b;
        7'd3: m_r[ins[8:6]] = a - b;
        7'd5: m_r[ins[8:6]] = a & b;
        7'd6: m_r[ins[8:6]] = a | b;
        7'd7: m_r[ins[8:6]] = a ^ b;
        default: ;
      endcase
    end else begin
      case (ins[15:11])
        5'd4: begin
          addr = b[A_SIZE-1:0];
          m_r[ins[10:8]] = m_ram[addr];
        end
        5'd5: m_r[ins[10:8]] = D_SIZE'(ins[7:0]);
        5'd6: begin
          addr = m_r[ins[10:8]][A_SIZE-1:0];
          m_ram[addr]    = b;
          m_ram_ok[addr] = 1'b1;
          last_store     = int'(addr);
        end
        5'd8: nxt = b[A_SIZE-1:0];
        5'd12: begin
          nxt    = m_pc;
          m_halt = 1'b1;
        end
        default: ;
      endcase
    end
    m_pc = nxt;
  endfunction

  // Compare process: advance the reference on each edge, then check the core.
  always @(posedge clk) begin
    model_step(rst, instruction);
    #1;
    check("pc", D_SIZE'(pc), D_SIZE'(m_pc));
    for (int i = 0; i < 8; i++)
      check($sformatf("R%0d", i), dut.r_rf[i], m_r[i]);
    if (last_store >= 0)
      check($sformatf("RAM[%0d]", last_store), dut.r_ram[last_store], m_ram[last_store]);
  end

  task automatic step(input logic [15:0] ins, input logic r);
    @(negedge clk);
    instruction = ins;
    rst         = r;
    @(posedge clk);
    #2;
  endtask

  // Random instruction, chosen from the current reference state so that LOADs
  // only read RAM words that have already been written.
  function automatic logic [15:0] gen_instr();
    int          sel;
    logic [2:0]  d;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [15:0] ins;
    int          start;
    bit          found;
    sel = $urandom_range(0, 99);
    d   = 3'($urandom);
    s1  = 3'($urandom);
    s2  = 3'($urandom);
    if (sel < 40) begin
      ins = {alu_ops[$urandom_range(0, 4)], d, s1, s2};
    end else if (sel < 45) begin
      ins = {nop_ops[$urandom_range(0, 5)], d, s1, s2};
    end else if (sel < 62) begin
      ins = {5'b00101, d, 8'($urandom)};
    end else if (sel < 72) begin
      ins = {5'b00110, d, 5'($urandom), s2};
    end else if (sel < 87) begin
      found = 1'b0;
      start = $urandom_range(0, 7);
      ins   = {5'b00101, d, 8'($urandom)};
      for (int j = 0; j < 8; j++) begin
        int k;
        k = (start + j) % 8;
        if (!found && m_ram_ok[m_r[k][A_SIZE-1:0]]) begin
          found = 1'b1;
          ins   = {5'b00100, d, 5'($urandom), 3'(k)};
        end
      end
    end else if (sel < 90) begin
      ins = {5'b01000, 3'($urandom), 5'($urandom), s2};
    end else if (sel < 91) begin
      ins = {5'b01100, 11'($urandom)};
    end else begin
      ins = 16'($urandom);
      while (ins[15:13] == 3'b000 || ins[15:11] == 5'd4 || ins[15:11] == 5'd5 ||
             ins[15:11] == 5'd6 || ins[15:11] == 5'd8 || ins[15:11] == 5'd12)
        ins = 16'($urandom);
    end
    return ins;
  endfunction

  initial begin
    int halt_cnt;
    // Reset for two edges, then free-run NOPs.
    step(16'h0000, 1'b0);
    step(16'h0000, 1'b0);
    check("reset_pc", D_SIZE'(pc), 0);
    check("reset_R5", dut.r_rf[5], 0);
    step(16'h0000, 1'b1);
    check("pc_after_release_1", D_SIZE'(pc), 1);
    step(16'h0000, 1'b1);
    check("pc_after_release_2", D_SIZE'(pc), 2);
    step(16'h0000, 1'b1);
    check("pc_after_release_3", D_SIZE'(pc), 3);

    // LOADC.
    step(16'h0000, 1'b0);
    step(16'h2807, 1'b1);
    step(16'h2906, 1'b1);
    check("loadc_R0", dut.r_rf[0], 7);
    check("loadc_R1", dut.r_rf[1], 6);
    step(16'h2C01, 1'b1);
    check("loadc_R4_zero_ext", dut.r_rf[4], 32'h0000_0001);

    // ALU program.
    step(16'h0000, 1'b0);
    step(16'h2807, 1'b1); step(16'h2906, 1'b1); step(16'h2A07, 1'b1); step(16'h2B07, 1'b1);
    step(16'h2C01, 1'b1); step(16'h2D07, 1'b1); step(16'h2E07, 1'b1); step(16'h2F07, 1'b1);
    step(16'h020B, 1'b1);
    check("add_R0", dut.r_rf[0], 13);
    check("model_add_R0", m_r[0], 13);
    step(16'h0287, 1'b1);
    check("add_R2", dut.r_rf[2], 20);
    step(16'h0601, 1'b1);
    check("sub_R0", dut.r_rf[0], 7);
    check("model_sub_R0", m_r[0], 7);
    check("pc_after_sub", D_SIZE'(pc), 11);

    // Memory.
    step(16'h3002, 1'b1);
    check("store_ram7", dut.r_ram[7], 20);
    step(16'h2000, 1'b1);
    check("load_R0", dut.r_rf[0], 20);
    check("model_load_R0", m_r[0], 20);

    // Wrapping subtract, JMP, HALT.
    step(16'h0763, 1'b1);
    check("sub_wrap_R5", dut.r_rf[5], 32'hFFFF_FFFA);
    check("model_sub_wrap_R5", m_r[5], 32'hFFFF_FFFA);
    step(16'h4004, 1'b1);
    check("jmp_pc", D_SIZE'(pc), 1);
    step(16'h6000, 1'b1);
    check("halt_pc", D_SIZE'(pc), 1);
    step(16'h28AA, 1'b1);
    step(16'h0000, 1'b1);
    step(16'h4004, 1'b1);
    check("halt_pc_frozen", D_SIZE'(pc), 1);
    check("halt_no_write_R0", dut.r_rf[0], 20);

    // pc wrap from 2**A_SIZE-1 to 0.
    step(16'h0000, 1'b0);
    step(16'h29FF, 1'b1);
    step(16'h0289, 1'b1);
    step(16'h0292, 1'b1);
    step(16'h4002, 1'b1);
    check("jmp_1020", D_SIZE'(pc), 1020);
    step(16'h0000, 1'b1); step(16'h0000, 1'b1); step(16'h0000, 1'b1);
    check("pc_1023", D_SIZE'(pc), 1023);
    step(16'h0000, 1'b1);
    check("pc_wrap_0", D_SIZE'(pc), 0);

    // Reset in the middle of a program.
    step(16'h0000, 1'b0);
    step(16'h2807, 1'b1);
    step(16'h2A21, 1'b1);
    step(16'h3002, 1'b1);
    step(16'h2A09, 1'b1);
    step(16'h3002, 1'b0);
    check("reset_store_blocked", dut.r_ram[7], 33);
    check("reset_mid_pc", D_SIZE'(pc), 0);
    step(16'h2906, 1'b1);
    step(16'h0201, 1'b0);
    check("reset_add_R0", dut.r_rf[0], 0);
    check("reset_add_pc", D_SIZE'(pc), 0);
    step(16'h2907, 1'b1);
    step(16'h2301, 1'b1);
    check("ram_survives_reset", dut.r_rf[3], 33);

    // Randomized program.
    halt_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      logic        r;
      logic [15:0] ins;
      r = 1'b1;
      if (m_halt) begin
        halt_cnt++;
        if (halt_cnt > 4) begin
          r        = 1'b0;
          halt_cnt = 0;
        end
      end else if ($urandom_range(0, 199) == 0) begin
        r = 1'b0;
      end
      ins = gen_instr();
      step(ins, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
